// File: rtl/clk_divider_multi_if.sv
// Configuration/control bundle and divided-clock status for clk_divider_multi.
// Latency: none (wires only); all timing lives in the divider itself.
// Backpressure: none; cfg_write and sync are single-cycle strobes that are always accepted.
interface clk_divider_multi_if #(
    parameter int NUM_CHANNELS       = 4,
    parameter int COUNTER_BITS       = 32,
    parameter int PULSE_CONTROL_BITS = 32,
    parameter int CH_SEL_BITS        = 2
) ();
    logic                          cfg_write;
    logic [CH_SEL_BITS-1:0]        cfg_ch;
    logic [1:0]                    cfg_mode;
    logic [COUNTER_BITS-1:0]       cfg_divider;
    logic [PULSE_CONTROL_BITS-1:0] cfg_pulse;
    logic                          sync;
    logic [NUM_CHANNELS-1:0]       out_enable;
    logic [NUM_CHANNELS-1:0]       clk_o;
    logic [NUM_CHANNELS-1:0]       busy;
    logic [NUM_CHANNELS-1:0]       done;

    // Controller side: drives configuration, observes outputs.
    modport master (
        output cfg_write, cfg_ch, cfg_mode, cfg_divider, cfg_pulse, sync, out_enable,
        input  clk_o, busy, done
    );

    // Divider side.
    modport slave (
        input  cfg_write, cfg_ch, cfg_mode, cfg_divider, cfg_pulse, sync, out_enable,
        output clk_o, busy, done
    );
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: free-run, counted burst of P periods, or stop.
// Latency: after a config write at edge E0, first clk_o rise at E0+D+1, first fall at E0+2D+2.
// Backpressure: none; writes to a channel index beyond NUM_CHANNELS are silently dropped.
module clk_divider_multi #(
    parameter int NUM_CHANNELS       = 4,
    parameter int COUNTER_BITS       = 32,
    parameter int PULSE_CONTROL_BITS = 32,
    parameter int CH_SEL_BITS        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    clk_divider_multi_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_t;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        ch_state_t                     st_q,   st_nxt;
        logic [COUNTER_BITS-1:0]       div_q,  div_nxt;
        logic [COUNTER_BITS-1:0]       cnt_q,  cnt_nxt;
        logic [PULSE_CONTROL_BITS-1:0] rem_q,  rem_nxt;
        logic                          ph_q,   ph_nxt;
        logic                          clk_o_q, busy_q, done_q;
        logic                          sel;
        logic                          active_nxt;

        // Only an exact channel match loads config; out-of-range indices match nothing.
        assign sel = bus.cfg_write && (bus.cfg_ch == CH_SEL_BITS'(i));

        // Next-state: config write beats sync, sync beats counting, burst ends on the 1->0 toggle.
        always_comb begin
            st_nxt  = st_q;
            div_nxt = div_q;
            cnt_nxt = cnt_q;
            rem_nxt = rem_q;
            ph_nxt  = ph_q;
            if (sel) begin
                div_nxt = bus.cfg_divider;
                rem_nxt = bus.cfg_pulse;
                cnt_nxt = '0;
                ph_nxt  = 1'b0;
                case (bus.cfg_mode)
                    2'b01:   st_nxt = ST_RUN;
                    2'b10:   st_nxt = (bus.cfg_pulse == '0) ? ST_DONE : ST_BURST;
                    default: st_nxt = ST_IDLE;
                endcase
            end else if (st_q == ST_RUN || st_q == ST_BURST) begin
                if (bus.sync) begin
                    // A high phase cut short here never reaches the decrement below.
                    cnt_nxt = '0;
                    ph_nxt  = 1'b0;
                end else if (cnt_q == div_q) begin
                    cnt_nxt = '0;
                    ph_nxt  = ~ph_q;
                    if (st_q == ST_BURST && ph_q) begin
                        rem_nxt = rem_q - PULSE_CONTROL_BITS'(1);
                        if (rem_q == PULSE_CONTROL_BITS'(1)) begin
                            st_nxt = ST_DONE;
                        end
                    end
                end else begin
                    cnt_nxt = cnt_q + COUNTER_BITS'(1);
                end
            end
        end

        assign active_nxt = (st_nxt == ST_RUN) || (st_nxt == ST_BURST);

        // State and registered outputs; clk_o is the gated next phase so it is glitch-free.
        always_ff @(posedge clk) begin
            if (reset) begin
                st_q    <= ST_IDLE;
                div_q   <= '0;
                cnt_q   <= '0;
                rem_q   <= '0;
                ph_q    <= 1'b0;
                clk_o_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                st_q    <= st_nxt;
                div_q   <= div_nxt;
                cnt_q   <= cnt_nxt;
                rem_q   <= rem_nxt;
                ph_q    <= ph_nxt;
                clk_o_q <= ph_nxt & bus.out_enable[i] & active_nxt;
                busy_q  <= active_nxt;
                done_q  <= (st_nxt == ST_DONE);
            end
        end

        assign bus.clk_o[i] = clk_o_q;
        assign bus.busy[i]  = busy_q;
        assign bus.done[i]  = done_q;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: vector table plus burst/gating/sync/reset sequences.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none.
module tb_clk_divider_multi;

    localparam int NCH = 4;
    localparam int CB  = 32;
    localparam int PB  = 32;
    localparam int CSB = 3;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    clk_divider_multi_if #(
        .NUM_CHANNELS(NCH), .COUNTER_BITS(CB), .PULSE_CONTROL_BITS(PB), .CH_SEL_BITS(CSB)
    ) bus ();

    clk_divider_multi #(
        .NUM_CHANNELS(NCH), .COUNTER_BITS(CB), .PULSE_CONTROL_BITS(PB), .CH_SEL_BITS(CSB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          wr;
        logic [2:0]    ch;
        logic [1:0]    mode;
        logic [31:0]   d;
        logic [31:0]   p;
        logic [3:0]    oe;
        logic [3:0]    e_clk;
        logic [3:0]    e_busy;
        logic [3:0]    e_done;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] mode,
                      input logic [31:0] d, input logic [31:0] p);
        bus.cfg_write   = 1'b1;
        bus.cfg_ch      = ch;
        bus.cfg_mode    = mode;
        bus.cfg_divider = d;
        bus.cfg_pulse   = p;
        tick();
        bus.cfg_write   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        logic prev;
        logic exp_b;
        logic en;

        reset           = 1'b0;
        bus.cfg_write   = 1'b0;
        bus.cfg_ch      = '0;
        bus.cfg_mode    = '0;
        bus.cfg_divider = '0;
        bus.cfg_pulse   = '0;
        bus.sync        = 1'b0;
        bus.out_enable  = 4'hF;

        // rst wr ch mode D P oe | clk_o busy done
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 2'b01, 32'd0, 32'd0, 4'hF, 4'h0, 4'h1, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h1, 4'h1, 4'h0};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h0, 4'h1, 4'h0};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h1, 4'h1, 4'h0};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h0, 4'h1, 4'h0};
        vecs[6]  = '{1'b0, 1'b1, 3'd7, 2'b01, 32'd0, 32'd0, 4'hF, 4'h1, 4'h1, 4'h0};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h0, 4'h1, 4'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'd3, 2'b10, 32'd0, 32'd0, 4'hF, 4'h1, 4'h1, 4'h8};
        vecs[9]  = '{1'b0, 1'b1, 3'd2, 2'b11, 32'd0, 32'd5, 4'hF, 4'h0, 4'h1, 4'h8};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h1, 4'h1, 4'h8};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h0, 4'h1, 4'h8};
        vecs[12] = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hE, 4'h0, 4'h1, 4'h8};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h0, 4'h1, 4'h8};
        vecs[14] = '{1'b0, 1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 4'hF, 4'h1, 4'h1, 4'h8};

        // Free-run D=0 on ch0, invalid channel write, P=0 burst, reserved mode, gating.
        for (int i = 0; i < 15; i++) begin
            reset           = vecs[i].rst;
            bus.cfg_write   = vecs[i].wr;
            bus.cfg_ch      = vecs[i].ch;
            bus.cfg_mode    = vecs[i].mode;
            bus.cfg_divider = vecs[i].d;
            bus.cfg_pulse   = vecs[i].p;
            bus.out_enable  = vecs[i].oe;
            tick();
            chk($sformatf("vec%0d clk_o", i), 32'(bus.clk_o), 32'(vecs[i].e_clk));
            chk($sformatf("vec%0d busy", i),  32'(bus.busy),  32'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i),  32'(bus.done),  32'(vecs[i].e_done));
        end
        reset          = 1'b0;
        bus.cfg_write  = 1'b0;
        bus.out_enable = 4'hF;

        // Burst ch1 D=2 P=3: high on edges k%6 in 3..5, done from edge 18.
        do_reset();
        wr(3'd1, 2'b10, 32'd2, 32'd3);
        pulses = 0;
        prev   = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_b = (k < 18) && ((k % 6) >= 3);
            chk($sformatf("burst clk_o k=%0d", k), 32'(bus.clk_o[1]), 32'(exp_b));
            chk($sformatf("burst done k=%0d", k),  32'(bus.done[1]),  32'(k >= 18));
            chk($sformatf("burst busy k=%0d", k),  32'(bus.busy[1]),  32'(k < 18));
            if (bus.clk_o[1] && !prev) pulses++;
            prev = bus.clk_o[1];
        end
        chk("burst pulse count", 32'(pulses), 32'd3);
        chk("burst others idle", 32'(bus.clk_o & 4'hD), 32'd0);

        // Burst ch2 D=1 P=4 with pulses 2-3 gated off; done still at edge 16.
        do_reset();
        wr(3'd2, 2'b10, 32'd1, 32'd4);
        for (int k = 1; k <= 20; k++) begin
            en = !((k >= 5) && (k <= 12));
            bus.out_enable = {1'b1, en, 2'b11};
            tick();
            exp_b = (k < 16) && ((k % 4) >= 2) && en;
            chk($sformatf("gate clk_o k=%0d", k), 32'(bus.clk_o[2]), 32'(exp_b));
            chk($sformatf("gate done k=%0d", k),  32'(bus.done[2]),  32'(k >= 16));
        end
        bus.out_enable = 4'hF;

        // Free-run ch0 D=1, ch3 D=3, then sync together with a config write to ch1.
        do_reset();
        wr(3'd0, 2'b01, 32'd1, 32'd0);
        wr(3'd3, 2'b01, 32'd3, 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("pre-sync ch0 high", 32'(bus.clk_o[0]), 32'd1);
        bus.sync = 1'b1;
        wr(3'd1, 2'b01, 32'd0, 32'd0);
        bus.sync = 1'b0;
        for (int m = 0; m <= 9; m++) begin
            if (m > 0) tick();
            chk($sformatf("sync ch0 m=%0d", m), 32'(bus.clk_o[0]), 32'((m % 4) >= 2));
            chk($sformatf("sync ch3 m=%0d", m), 32'(bus.clk_o[3]), 32'((m % 8) >= 4));
            chk($sformatf("sync ch1 m=%0d", m), 32'(bus.clk_o[1]), 32'((m % 2) == 1));
        end

        // Config write lands on the edge a P=1 burst would complete: no done.
        do_reset();
        wr(3'd1, 2'b10, 32'd0, 32'd1);
        tick();
        chk("race pulse high", 32'(bus.clk_o[1]), 32'd1);
        wr(3'd1, 2'b00, 32'd0, 32'd0);
        chk("race done", 32'(bus.done[1]), 32'd0);
        chk("race busy", 32'(bus.busy[1]), 32'd0);
        tick();
        chk("race done later", 32'(bus.done[1]), 32'd0);

        // Reset in the middle of a burst aborts without done.
        do_reset();
        wr(3'd1, 2'b10, 32'd0, 32'd10);
        tick();
        tick();
        tick();
        chk("midburst busy", 32'(bus.busy), 32'h2);
        do_reset();
        chk("rst clk_o", 32'(bus.clk_o), 32'd0);
        chk("rst busy",  32'(bus.busy),  32'd0);
        chk("rst done",  32'(bus.done),  32'd0);
        tick();
        tick();
        tick();
        chk("post-rst clk_o", 32'(bus.clk_o), 32'd0);
        chk("post-rst done",  32'(bus.done),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
